// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the asymmetric-width FIFO.
//  - MODE_* / DIR_*  : legal values of the MODE and DIRECTION string parameters
//  - narrow_w/wide_w : smaller/larger of the two port widths
//  - width_ratio     : wide/narrow lane count per storage word
//  - cnt_w           : width of a 0..depth inclusive counter
//  - ptr_w           : address width for a power-of-2 depth (min 1)
package sync_fifo_pkg;

    localparam string MODE_STD  = "Standard";
    localparam string MODE_FWFT = "FWFT";
    localparam string DIR_LSB   = "LSB";
    localparam string DIR_MSB   = "MSB";

    function automatic int narrow_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int wide_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int width_ratio(input int a, input int b);
        return wide_w(a, b) / narrow_w(a, b);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage, one wide word per address split into lanes.
//  clk      : clock
//  we       : write strobe, lane_en selects which lanes of wr_addr are written
//  wr_data  : write word (all lanes; unselected lanes ignored)
//  rd_addr  : read address, sampled every cycle
//  rd_data  : registered read word, write-first per lane when wr_addr==rd_addr
// The write-first bypass lets the caller keep rd_data equal to the current
// contents of the word it is pointing at, even while that word is being filled.
module sync_fifo_ram #(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [NUM_LANES-1:0]               lane_en,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]   wr_data,
    input  logic [AW-1:0]                      rd_addr,
    output logic [NUM_LANES-1:0][LANE_W-1:0]   rd_data
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rd_q;
        logic              wr_hit;

        assign wr_hit = we && lane_en[k];

        always_ff @(posedge clk) begin
            if (wr_hit) begin
                mem[wr_addr] <= wr_data[k];
            end
            if (wr_hit && (wr_addr == rd_addr)) begin
                rd_q <= wr_data[k];
            end else begin
                rd_q <= mem[rd_addr];
            end
        end

        assign rd_data[k] = rd_q;
    end

endmodule

// File: rtl/sync_fifo_asym.sv
// Single-clock FIFO with different write and read widths (power-of-2 ratio).
//  sys_clk/sys_rst : clock, synchronous active-high reset
//  wr_en/din       : write request and write word (INPUT_WIDTH)
//  rd_en/dout      : read request (FWFT: acknowledge of shown word), read word
//  valid           : dout carries a read word this cycle
//  full/empty      : no write word free / no complete read word stored
//  prog_full/empty : threshold flags on wr_data_count / rd_data_count
//  overflow/underflow : one-cycle pulse after a rejected write / read
//  wr_/rd_data_count, wr_/rd_data_space : stored and free words per side
// Storage is one wide word per address; the narrow side walks the lanes of
// the current word with a sub-pointer. Occupancy is a single counter in
// narrow units, and every flag and count derives from its next value.
module sync_fifo_asym
    import sync_fifo_pkg::*;
#(
    parameter int    INPUT_WIDTH       = 64,
    parameter int    OUTPUT_WIDTH      = 8,
    parameter int    WR_DEPTH          = 16,
    parameter int    RD_DEPTH          = 128,
    parameter string MODE              = "Standard",
    parameter string DIRECTION         = "LSB",
    parameter int    PROG_FULL_THRESH  = 12,
    parameter int    PROG_EMPTY_THRESH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        wr_en,
    input  logic [INPUT_WIDTH-1:0]      din,
    input  logic                        rd_en,
    output logic [OUTPUT_WIDTH-1:0]     dout,
    output logic                        valid,
    output logic                        full,
    output logic                        empty,
    output logic                        prog_full,
    output logic                        prog_empty,
    output logic                        overflow,
    output logic                        underflow,
    output logic [$clog2(WR_DEPTH):0]   wr_data_count,
    output logic [$clog2(WR_DEPTH):0]   wr_data_space,
    output logic [$clog2(RD_DEPTH):0]   rd_data_count,
    output logic [$clog2(RD_DEPTH):0]   rd_data_space
);

    localparam int NW    = narrow_w(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int WW    = wide_w(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int R     = width_ratio(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int WR_R  = (OUTPUT_WIDTH > INPUT_WIDTH) ? R : 1;  // writes per storage word
    localparam int RD_R  = (INPUT_WIDTH > OUTPUT_WIDTH) ? R : 1;  // reads per storage word
    localparam int WR_U  = INPUT_WIDTH / NW;
    localparam int RD_U  = OUTPUT_WIDTH / NW;
    localparam int CAP   = WR_DEPTH * WR_U;
    localparam int WORDS = CAP / R;
    localparam int AW    = ptr_w(WORDS);
    localparam int SW    = ptr_w(R);
    localparam int UW    = $clog2(CAP) + 1;
    localparam int WCW   = cnt_w(WR_DEPTH);
    localparam int RCW   = cnt_w(RD_DEPTH);
    localparam int WR_SH = $clog2(WR_U);
    localparam int RD_SH = $clog2(RD_U);
    localparam bit IS_FWFT = (MODE == MODE_FWFT);
    localparam bit IS_MSB  = (DIRECTION == DIR_MSB);
    localparam bit PF_RST  = (PROG_FULL_THRESH <= 0);
    localparam bit PE_RST  = (PROG_EMPTY_THRESH >= 0);

    if (INPUT_WIDTH * WR_DEPTH != OUTPUT_WIDTH * RD_DEPTH) begin : g_err_cap
        $error("sync_fifo_asym: WR_DEPTH*INPUT_WIDTH must equal RD_DEPTH*OUTPUT_WIDTH");
    end
    if ((WW % NW) != 0 || (R & (R - 1)) != 0 || R > 16) begin : g_err_ratio
        $error("sync_fifo_asym: width ratio must be a power of 2 up to 16");
    end
    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_err_depth
        $error("sync_fifo_asym: depth must be a power of 2 of at least 2 storage words");
    end
    if (MODE != MODE_STD && MODE != MODE_FWFT) begin : g_err_mode
        $error("sync_fifo_asym: MODE must be Standard or FWFT");
    end
    if (DIRECTION != DIR_LSB && DIRECTION != DIR_MSB) begin : g_err_dir
        $error("sync_fifo_asym: DIRECTION must be LSB or MSB");
    end

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]  wr_sub_q, wr_sub_d, rd_sub_q, rd_sub_d;
    logic [UW-1:0]  units_q, units_d;
    logic           full_q, full_d, empty_q, empty_d;
    logic           prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
    logic           overflow_q, overflow_d, underflow_q, underflow_d;
    logic           valid_q, valid_d;
    logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;
    logic [WCW-1:0] wr_cnt_q, wr_cnt_d, wr_space_q, wr_space_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d, rd_space_q, rd_space_d;

    logic                    wr_acc, rd_acc;
    logic [SW-1:0]           wr_lane;
    logic [R-1:0]            lane_en;
    logic [R-1:0][NW-1:0]    ram_wdata, ram_rdata;
    logic [AW-1:0]           ram_raddr;
    logic [OUTPUT_WIDTH-1:0] head_word;

    // Flags are the pre-edge view: a simultaneous pop never makes room for a
    // write rejected as full, and vice versa.
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_sub_d = wr_sub_q;
        rd_ptr_d = rd_ptr_q;
        rd_sub_d = rd_sub_q;
        if (wr_acc) begin
            if (wr_sub_q == SW'(WR_R - 1)) begin
                wr_sub_d = '0;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_sub_d = wr_sub_q + SW'(1);
            end
        end
        if (rd_acc) begin
            if (rd_sub_q == SW'(RD_R - 1)) begin
                rd_sub_d = '0;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_sub_d = rd_sub_q + SW'(1);
            end
        end

        units_d = units_q + (wr_acc ? UW'(WR_U) : '0) - (rd_acc ? UW'(RD_U) : '0);
        full_d  = (UW'(CAP) - units_d) < UW'(WR_U);
        empty_d = units_d < UW'(RD_U);

        wr_cnt_d     = WCW'(units_d >> WR_SH);
        rd_cnt_d     = RCW'(units_d >> RD_SH);
        wr_space_d   = WCW'(WR_DEPTH) - wr_cnt_d;
        rd_space_d   = RCW'(RD_DEPTH) - rd_cnt_d;
        prog_full_d  = wr_cnt_d >= WCW'(PROG_FULL_THRESH);
        prog_empty_d = rd_cnt_d <= RCW'(PROG_EMPTY_THRESH);

        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;

        valid_d = rd_acc;
        dout_d  = rd_acc ? head_word : dout_q;
    end

    // Narrow writes land in one lane of the tail word; wide writes fill all.
    always_comb begin
        wr_lane = IS_MSB ? (SW'(R - 1) - wr_sub_q) : wr_sub_q;
        lane_en = '0;
        for (int k = 0; k < R; k++) begin
            lane_en[k] = (WR_R == 1) || (wr_lane == SW'(k));
        end
    end

    assign ram_wdata = {(WW / INPUT_WIDTH){din}};

    // Reading next cycle's head address keeps the RAM output register equal
    // to the live head word; it doubles as the FWFT prefetch register.
    assign ram_raddr = sys_rst ? '0 : rd_ptr_d;

    sync_fifo_ram #(
        .LANE_W    (NW),
        .NUM_LANES (R),
        .DEPTH     (WORDS),
        .AW        (AW)
    ) u_ram (
        .clk     (sys_clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr_q),
        .lane_en (lane_en),
        .wr_data (ram_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    if (RD_R > 1) begin : g_rd_narrow
        logic [SW-1:0] rd_lane;
        assign rd_lane   = IS_MSB ? (SW'(R - 1) - rd_sub_q) : rd_sub_q;
        assign head_word = ram_rdata[rd_lane];
    end else begin : g_rd_wide
        assign head_word = ram_rdata;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q     <= '0;
            wr_sub_q     <= '0;
            rd_ptr_q     <= '0;
            rd_sub_q     <= '0;
            units_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_full_q  <= PF_RST;
            prog_empty_q <= PE_RST;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            valid_q      <= 1'b0;
            dout_q       <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_space_q   <= WCW'(WR_DEPTH);
            rd_space_q   <= RCW'(RD_DEPTH);
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_sub_q     <= wr_sub_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_sub_q     <= rd_sub_d;
            units_q      <= units_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            valid_q      <= valid_d;
            dout_q       <= dout_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_space_q   <= wr_space_d;
            rd_space_q   <= rd_space_d;
        end
    end

    if (IS_FWFT) begin : g_fwft
        assign valid = !empty_q;
        assign dout  = empty_q ? '0 : head_word;
    end else begin : g_std
        assign valid = valid_q;
        assign dout  = dout_q;
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign prog_full     = prog_full_q;
    assign prog_empty    = prog_empty_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign wr_data_count = wr_cnt_q;
    assign wr_data_space = wr_space_q;
    assign rd_data_count = rd_cnt_q;
    assign rd_data_space = rd_space_q;

endmodule

// File: tb/tb_sync_fifo_asym.sv
// Bench for sync_fifo_asym: instance 0 is 64->8 FWFT LSB, instance 1 is
// 8->64 Standard MSB. The reference is a plain byte FIFO per instance.
module tb_sync_fifo_asym;

    localparam int CAP = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst;
    logic        wr_a, rd_a, wr_b, rd_b;
    logic [63:0] din_a;
    logic [7:0]  din_b;
    logic [7:0]  dout_a;
    logic [63:0] dout_b;
    logic        valid_a, full_a, empty_a, pf_a, pe_a, ovf_a, udf_a;
    logic        valid_b, full_b, empty_b, pf_b, pe_b, ovf_b, udf_b;
    logic [4:0]  wc_a, ws_a, rc_b, rs_b;
    logic [7:0]  rc_a, rs_a, wc_b, ws_b;

    sync_fifo_asym #(
        .INPUT_WIDTH(64), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(128),
        .MODE("FWFT"), .DIRECTION("LSB"), .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)
    ) dut_a (
        .sys_clk(clk), .sys_rst(sys_rst), .wr_en(wr_a), .din(din_a), .rd_en(rd_a),
        .dout(dout_a), .valid(valid_a), .full(full_a), .empty(empty_a),
        .prog_full(pf_a), .prog_empty(pe_a), .overflow(ovf_a), .underflow(udf_a),
        .wr_data_count(wc_a), .wr_data_space(ws_a), .rd_data_count(rc_a), .rd_data_space(rs_a)
    );

    sync_fifo_asym #(
        .INPUT_WIDTH(8), .OUTPUT_WIDTH(64), .WR_DEPTH(128), .RD_DEPTH(16),
        .MODE("Standard"), .DIRECTION("MSB"), .PROG_FULL_THRESH(100), .PROG_EMPTY_THRESH(2)
    ) dut_b (
        .sys_clk(clk), .sys_rst(sys_rst), .wr_en(wr_b), .din(din_b), .rd_en(rd_b),
        .dout(dout_b), .valid(valid_b), .full(full_b), .empty(empty_b),
        .prog_full(pf_b), .prog_empty(pe_b), .overflow(ovf_b), .underflow(udf_b),
        .wr_data_count(wc_b), .wr_data_space(ws_b), .rd_data_count(rc_b), .rd_data_space(rs_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference: byte FIFO per instance plus the pulses expected after the edge.
    logic [7:0]  m_buf [2][CAP];
    int          m_head [2];
    int          m_cnt [2];
    logic        m_ovf [2];
    logic        m_udf [2];
    logic        m_vld [2];
    int          wu  [2] = '{8, 1};
    int          ru  [2] = '{1, 8};
    bit          msb [2] = '{1'b0, 1'b1};
    int          pft [2] = '{12, 100};
    int          pet [2] = '{4, 2};
    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_head[id] = 0;
            m_cnt[id]  = 0;
            m_ovf[id]  = 1'b0;
            m_udf[id]  = 1'b0;
            m_vld[id]  = 1'b0;
        end
    endtask

    task automatic model_step(input int id, input logic wr, input logic rd, input logic [63:0] d);
        bit          mfull, mempty, wacc, racc;
        logic [63:0] w;
        logic [7:0]  b;
        mfull  = (CAP - m_cnt[id]) < wu[id];
        mempty = m_cnt[id] < ru[id];
        wacc   = wr && !mfull;
        racc   = rd && !mempty;
        m_ovf[id] = wr && mfull;
        m_udf[id] = rd && mempty;
        m_vld[id] = racc;
        if (racc) begin
            w = '0;
            for (int j = 0; j < ru[id]; j++) begin
                b = m_buf[id][(m_head[id] + j) % CAP];
                if (msb[id]) w = {w[55:0], b};
                else         w = w | (64'(b) << (8 * j));
            end
            m_head[id] = (m_head[id] + ru[id]) % CAP;
            m_cnt[id]  = m_cnt[id] - ru[id];
            if (id == 0) exp_a.push_back(w);
            else         exp_b.push_back(w);
        end
        if (wacc) begin
            for (int j = 0; j < wu[id]; j++) begin
                m_buf[id][(m_head[id] + m_cnt[id]) % CAP] =
                    msb[id] ? d[8 * (wu[id] - 1 - j) +: 8] : d[8 * j +: 8];
                m_cnt[id]++;
            end
        end
    endtask

    task automatic check_state(input int id);
        logic f, e, pf, pe, ov, ud, v;
        int   wc, ws, rc, rs, c, ewc, erc;
        if (id == 0) begin
            f = full_a; e = empty_a; pf = pf_a; pe = pe_a; ov = ovf_a; ud = udf_a; v = valid_a;
            wc = int'(wc_a); ws = int'(ws_a); rc = int'(rc_a); rs = int'(rs_a);
        end else begin
            f = full_b; e = empty_b; pf = pf_b; pe = pe_b; ov = ovf_b; ud = udf_b; v = valid_b;
            wc = int'(wc_b); ws = int'(ws_b); rc = int'(rc_b); rs = int'(rs_b);
        end
        c   = m_cnt[id];
        ewc = c / wu[id];
        erc = c / ru[id];
        chk("full",          id, 64'(f),  64'((CAP - c) < wu[id]));
        chk("empty",         id, 64'(e),  64'(c < ru[id]));
        chk("wr_data_count", id, 64'(wc), 64'(ewc));
        chk("wr_data_space", id, 64'(ws), 64'(CAP / wu[id] - ewc));
        chk("rd_data_count", id, 64'(rc), 64'(erc));
        chk("rd_data_space", id, 64'(rs), 64'(CAP / ru[id] - erc));
        chk("prog_full",     id, 64'(pf), 64'(ewc >= pft[id]));
        chk("prog_empty",    id, 64'(pe), 64'(erc <= pet[id]));
        chk("overflow",      id, 64'(ov), 64'(m_ovf[id]));
        chk("underflow",     id, 64'(ud), 64'(m_udf[id]));
        // FWFT shows the head whenever a word is stored; Standard answers reads.
        chk("valid",         id, 64'(v),  id == 0 ? 64'(c >= ru[id]) : 64'(m_vld[id]));
    endtask

    task automatic cycle(input logic wa, input logic ra, input logic [63:0] da,
                         input logic wb, input logic rb, input logic [63:0] db);
        model_step(0, wa, ra, da);
        model_step(1, wb, rb, db);
        wr_a = wa; rd_a = ra; din_a = da;
        wr_b = wb; rd_b = rb; din_b = db[7:0];
        @(posedge clk); #2;
        check_state(0);
        check_state(1);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        wr_a = 1'b0; rd_a = 1'b0; din_a = '0;
        wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
        sys_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        sys_rst = 1'b0;
        model_reset();
        check_state(0);
        check_state(1);
        chk("dout_rst", 1, dout_b, 64'h0);
    endtask

    // Monitors: FWFT consumes the shown word on rd_en; Standard presents on valid.
    always @(negedge clk) begin
        if (!sys_rst && valid_a && rd_a) begin
            if (exp_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL dout inst0: popped %0h with no word expected", dout_a);
            end else begin
                chk("dout", 0, 64'(dout_a), exp_a.pop_front());
            end
        end
        if (!sys_rst && valid_b) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL dout inst1: presented %0h with no word expected", dout_b);
            end else begin
                chk("dout", 1, dout_b, exp_b.pop_front());
            end
        end
    end

    int pw [5] = '{90, 30, 70, 100, 50};
    int pr [5] = '{30, 90, 70, 100, 10};

    initial begin
        model_reset();
        do_reset();

        // Lane order on both sides: one wide word out as bytes, bytes in as one word.
        cycle(1'b1, 1'b0, 64'h0123_4567_89ab_cdef, 1'b1, 1'b0, 64'h01);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, '0, 1'b1, 1'b0, 64'(i + 2));
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
        idle();

        // Reads on empty, alone and together with a write.
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 64'h55);
        idle();
        idle();

        // Fill to full and keep writing.
        do_reset();
        for (int i = 0; i < 132; i++)
            cycle(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 64'($urandom));
        idle();

        // Simultaneous write and read from a two-word occupancy.
        do_reset();
        cycle(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 64'($urandom));
        cycle(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 64'($urandom));
        cycle(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 64'($urandom));
        idle();
        idle();

        // Reset with a partially assembled wide word.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 64'($urandom));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 64'($urandom));
        idle();
        do_reset();

        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(99) < pw[s], $urandom_range(99) < pr[s], {$urandom, $urandom},
                      $urandom_range(99) < pw[s], $urandom_range(99) < pr[s], 64'($urandom));
            if (s == 2) begin
                idle();
                idle();
                do_reset();
            end
        end

        for (int i = 0; i < 140; i++) cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, '0);
        idle();
        idle();
        chk("leftover", 0, 64'(exp_a.size()), 64'h0);
        chk("leftover", 1, 64'(exp_b.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
